blit_copy_engine: RTL and testbench
===================================

Name: blit_copy_engine

Overview:
- Blitter-side DMA sequencer that copies a rectangle of 32-bit words from a source region of SDRAM to a destination region.
- Drives the arbiter's blitter read port (burst reads) and blitter write port (single writes).
- Stages one burst at a time in a local buffer.
- Configured and started by the CPU-side blitter register block; reports busy/done.

Parameters:
BURST_LEN, 16, words returned per burst read and depth of the staging buffer (power of 2, 4..32)

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latches config when idle
src_addr  input  26  source byte address of the rectangle's first word (bits[1:0] ignored)
dst_addr  input  26  destination byte address (bits[1:0] ignored)
width_words  input  12  words per row
height  input  12  number of rows
src_stride  input  16  byte increment between source row starts
dst_stride  input  16  byte increment between destination row starts
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
blitr_request  output  1  burst read request
blitr_address  output  26  burst read start address
blitr_ack  input  1  read request accepted (may be same cycle as request)
blitr_rdata  input  32  read data
blitr_valid  input  1  read data word valid
blitr_complete  input  1  burst finished
blitw_request  output  1  write request
blitw_address  output  26  write address
blitw_wdata  output  32  write data
blitw_byte_en  output  4  byte enables; always 4'hF
blitw_ack  input  1  write request accepted

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, blitr_request=0, blitw_request=0. Addresses and wdata are 0; blitw_byte_en=4'hF.
- Reset mid-operation: the engine returns to IDLE in one cycle and both requests drop. Later valid/complete beats from an abandoned burst are ignored.
- start is ignored while busy.
- When idle, start latches the config. busy rises the next cycle.
- If width_words==0 or height==0: done pulses 1 cycle after start, busy stays 0, and no requests are issued.
- Chunk = min(BURST_LEN, words remaining in the current row).
- State machine:
  - IDLE.
  - RD_REQ: blitr_request=1, blitr_address=current src word. On blitr_ack the request is 0 the next cycle and the state goes to RD_DATA.
  - RD_DATA: each blitr_valid writes blitr_rdata into buffer[idx] and increments idx. Beats with idx ≥ chunk are discarded, because the burst always returns BURST_LEN words. On blitr_complete the state goes to WR. valid and complete in the same cycle: store first, then transition.
  - WR: blitw_request=1 with buffer[widx], blitw_address = dst + 4*widx. On blitw_ack, the next cycle presents the next word with the request held high, so back-to-back writes are allowed. After the ack of word chunk-1 the request drops and the state goes to ADV.
  - ADV: advance the column by chunk. If the row is finished, advance the row by adding the strides to the row-start addresses and reset the column. If rows remain, go to RD_REQ; otherwise pulse done, clear busy, and go to IDLE.
- Address arithmetic is modulo 2^26 (wrap-around); strides are unsigned.
- Throughput: for every burst, exactly one read request is followed by exactly chunk write requests. Reads and writes never overlap.

Optional Feature:
- Macro: BLIT_FILL_EN.
- Defined:
  - Extra inputs fill_mode (1) and fill_value (32) are latched on start.
  - With fill_mode=1, RD_REQ and RD_DATA are skipped and every write uses fill_value.
  - blitr_request is never asserted.
- Undefined: these ports do not exist and the engine behaves as copy-only.

Decomposition:
- Shared package blit_pkg holds:
  - the FSM state encoding;
  - the arbiter master ID constants (CPU=1, VGA=2, BLITW=3, BLITR=4);
  - WORD_BYTES=4.
- One sub-module, blit_stage_buffer: a BURST_LEN×32 register file with synchronous write and combinational read.

Test Plan:
- Copy of a 4×2 rectangle, src=0x1000, dst=0x2000, strides 0x100/0x200, ack on the same cycle → exactly 2 read requests (0x1000, 0x1100). Exactly 8 writes to 0x2000–0x200C and 0x2200–0x220C with matching data. done pulses once.
- width_words=20, BURST_LEN=16 → reads at src and src+0x40. The second burst's beats 4..15 are discarded. 20 writes total.
- Acks delayed 3 cycles, with valid gaps mid-burst → requests stay high until ack. No duplicate or missing writes. Data order is preserved.
- height=0 → done 1 cycle after start, busy never 1, no requests. A second start during an active copy is ignored.
- Reset asserted in RD_DATA with 5 beats still to arrive → requests go low the next cycle and the late beats are ignored. A following start copies correctly.
- With BLIT_FILL_EN: fill_mode=1, fill_value=0xDEADBEEF, 3×3 → 9 writes of 0xDEADBEEF, blitr_request never high.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter copy engine: FSM encoding, arbiter master IDs, word size.
package blit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR,
    ST_ADV
  } blit_state_t;

  // Arbiter port identities, kept here so the arbiter and blitter agree on numbering.
  typedef enum logic [2:0] {
    MID_CPU   = 3'd1,
    MID_VGA   = 3'd2,
    MID_BLITW = 3'd3,
    MID_BLITR = 3'd4
  } blit_master_id_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/blit_copy_engine_if.sv
// Blitter read (burst) and write (single) ports towards the SDRAM arbiter.
interface blit_copy_engine_if;
  logic        blitr_request;
  logic [25:0] blitr_address;
  logic        blitr_ack;
  logic [31:0] blitr_rdata;
  logic        blitr_valid;
  logic        blitr_complete;
  logic        blitw_request;
  logic [25:0] blitw_address;
  logic [31:0] blitw_wdata;
  logic [3:0]  blitw_byte_en;
  logic        blitw_ack;

  modport master (
    output blitr_request, blitr_address,
    input  blitr_ack, blitr_rdata, blitr_valid, blitr_complete,
    output blitw_request, blitw_address, blitw_wdata, blitw_byte_en,
    input  blitw_ack
  );

  modport slave (
    input  blitr_request, blitr_address,
    output blitr_ack, blitr_rdata, blitr_valid, blitr_complete,
    input  blitw_request, blitw_address, blitw_wdata, blitw_byte_en,
    output blitw_ack
  );
endinterface

// File: rtl/blit_stage_buffer.sv
// Staging store for one read burst: synchronous write, combinational read.
module blit_stage_buffer #(
  parameter int BURST_LEN = 16
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [$clog2(BURST_LEN)-1:0] i_waddr,
  input  logic [31:0]                  i_wdata,
  input  logic [$clog2(BURST_LEN)-1:0] i_raddr,
  output logic [31:0]                  o_rdata
);
  localparam int AW = $clog2(BURST_LEN);

  logic [31:0] r_mem [BURST_LEN];

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_word
    always_ff @(posedge i_clk) begin
      if (i_we && i_waddr == AW'(gi)) r_mem[gi] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/blit_copy_engine.sv
// Rectangle copy sequencer: one burst read into a staging buffer, then chunk single writes.
// Optional solid fill (no reads) is enabled by defining BLIT_FILL_EN.
module blit_copy_engine
  import blit_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] src_addr,
  input  logic [25:0] dst_addr,
  input  logic [11:0] width_words,
  input  logic [11:0] height,
  input  logic [15:0] src_stride,
  input  logic [15:0] dst_stride,
`ifdef BLIT_FILL_EN
  input  logic        fill_mode,
  input  logic [31:0] fill_value,
`endif
  output logic        busy,
  output logic        done,
  blit_copy_engine_if.master bus
);
  localparam int          AW      = $clog2(BURST_LEN);
  localparam logic [11:0] BURST_W = 12'(BURST_LEN);
  localparam logic [25:0] WB      = 26'(WORD_BYTES);

  blit_state_t r_state, w_state_next;
  logic [11:0] r_width, w_width_next, r_rows, w_rows_next, r_col, w_col_next;
  logic [11:0] r_idx, w_idx_next, r_widx, w_widx_next;
  logic [25:0] r_src_row, w_src_row_next, r_dst_row, w_dst_row_next;
  logic [15:0] r_src_stride, w_src_stride_next, r_dst_stride, w_dst_stride_next;
  logic        r_busy, w_busy_next, r_done, w_done_next, r_rreq, r_wreq;
  logic [25:0] r_raddr, w_raddr_next, r_waddr, w_waddr_next;
  logic [31:0] r_wdata, w_wdata_next, w_buf_rdata, w_fill_value_next;
  logic [11:0] w_remain, w_chunk, w_col_sum;
  logic        w_buf_we, w_fill_active, w_fill_next, w_accept;
  logic        w_unused_ok;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_unused_ok = &{1'b0, src_addr[1:0], dst_addr[1:0]};

`ifdef BLIT_FILL_EN
  logic        r_fill_mode;
  logic [31:0] r_fill_value;
  assign w_fill_active     = r_fill_mode;
  assign w_fill_next       = w_accept ? fill_mode : r_fill_mode;
  assign w_fill_value_next = w_accept ? fill_value : r_fill_value;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill_mode  <= 1'b0;
      r_fill_value <= 32'd0;
    end else begin
      r_fill_mode  <= w_fill_next;
      r_fill_value <= w_fill_value_next;
    end
  end
`else
  assign w_fill_active     = 1'b0;
  assign w_fill_next       = 1'b0;
  assign w_fill_value_next = 32'd0;
`endif

  // The burst always returns BURST_LEN beats; only the first chunk of them are kept.
  assign w_remain  = r_width - r_col;
  assign w_chunk   = (w_remain > BURST_W) ? BURST_W : w_remain;
  assign w_col_sum = r_col + w_chunk;
  assign w_buf_we  = (r_state == ST_RD_DATA) && bus.blitr_valid && (r_idx < w_chunk);

  blit_stage_buffer #(.BURST_LEN(BURST_LEN)) u_stage_buffer (
    .i_clk   (clock),
    .i_we    (w_buf_we),
    .i_waddr (r_idx[AW-1:0]),
    .i_wdata (bus.blitr_rdata),
    .i_raddr (w_widx_next[AW-1:0]),
    .o_rdata (w_buf_rdata)
  );

  always_comb begin
    w_state_next      = r_state;
    w_width_next      = r_width;
    w_rows_next       = r_rows;
    w_col_next        = r_col;
    w_idx_next        = r_idx;
    w_widx_next       = r_widx;
    w_src_row_next    = r_src_row;
    w_dst_row_next    = r_dst_row;
    w_src_stride_next = r_src_stride;
    w_dst_stride_next = r_dst_stride;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (width_words == 12'd0 || height == 12'd0) begin
            w_done_next = 1'b1;
          end else begin
            w_width_next      = width_words;
            w_rows_next       = height;
            w_col_next        = 12'd0;
            w_widx_next       = 12'd0;
            w_src_row_next    = {src_addr[25:2], 2'b00};
            w_dst_row_next    = {dst_addr[25:2], 2'b00};
            w_src_stride_next = src_stride;
            w_dst_stride_next = dst_stride;
            w_busy_next       = 1'b1;
            w_state_next      = w_fill_next ? ST_WR : ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (bus.blitr_ack) begin
          w_idx_next   = 12'd0;
          w_state_next = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (w_buf_we) w_idx_next = r_idx + 12'd1;
        if (bus.blitr_complete) begin
          w_widx_next  = 12'd0;
          w_state_next = ST_WR;
        end
      end
      ST_WR: begin
        if (bus.blitw_ack) begin
          if (r_widx == w_chunk - 12'd1) w_state_next = ST_ADV;
          else                           w_widx_next  = r_widx + 12'd1;
        end
      end
      ST_ADV: begin
        w_widx_next  = 12'd0;
        w_state_next = w_fill_active ? ST_WR : ST_RD_REQ;
        if (w_col_sum >= r_width) begin
          w_col_next     = 12'd0;
          w_rows_next    = r_rows - 12'd1;
          w_src_row_next = r_src_row + {10'd0, r_src_stride};
          w_dst_row_next = r_dst_row + {10'd0, r_dst_stride};
          if (r_rows == 12'd1) begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_col_next = w_col_sum;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they belong to.
  assign w_raddr_next = w_src_row_next + 26'(w_col_next) * WB;
  assign w_waddr_next = w_dst_row_next + 26'(w_col_next + w_widx_next) * WB;
  assign w_wdata_next = w_fill_next ? w_fill_value_next :
                        (w_buf_we && r_idx == w_widx_next) ? bus.blitr_rdata : w_buf_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_width      <= 12'd0;
      r_rows       <= 12'd0;
      r_col        <= 12'd0;
      r_idx        <= 12'd0;
      r_widx       <= 12'd0;
      r_src_row    <= 26'd0;
      r_dst_row    <= 26'd0;
      r_src_stride <= 16'd0;
      r_dst_stride <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rreq       <= 1'b0;
      r_wreq       <= 1'b0;
      r_raddr      <= 26'd0;
      r_waddr      <= 26'd0;
      r_wdata      <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_width      <= w_width_next;
      r_rows       <= w_rows_next;
      r_col        <= w_col_next;
      r_idx        <= w_idx_next;
      r_widx       <= w_widx_next;
      r_src_row    <= w_src_row_next;
      r_dst_row    <= w_dst_row_next;
      r_src_stride <= w_src_stride_next;
      r_dst_stride <= w_dst_stride_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_rreq       <= (w_state_next == ST_RD_REQ);
      r_wreq       <= (w_state_next == ST_WR);
      r_raddr      <= w_raddr_next;
      r_waddr      <= w_waddr_next;
      r_wdata      <= w_wdata_next;
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign bus.blitr_request = r_rreq;
  assign bus.blitr_address = r_raddr;
  assign bus.blitw_request = r_wreq;
  assign bus.blitw_address = r_waddr;
  assign bus.blitw_wdata   = r_wdata;
  assign bus.blitw_byte_en = 4'hF;
endmodule

// File: tb/tb_blit_copy_engine.sv
// Directed bench for blit_copy_engine with a behavioural SDRAM-arbiter responder.
module tb_blit_copy_engine;
  import blit_pkg::*;

  localparam int BL = 16;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [25:0] src_addr, dst_addr;
  logic [11:0] width_words, height;
  logic [15:0] src_stride, dst_stride;
  logic        busy, done;
`ifdef BLIT_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_value;
`endif

  blit_copy_engine_if bus ();

  blit_copy_engine #(.BURST_LEN(BL)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .width_words (width_words),
    .height      (height),
    .src_stride  (src_stride),
    .dst_stride  (dst_stride),
`ifdef BLIT_FILL_EN
    .fill_mode   (fill_mode),
    .fill_value  (fill_value),
`endif
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  int rd_delay = 0, wr_delay = 0;
  bit rd_gaps  = 1'b0;
  bit rd_active = 1'b0;
  int rd_beat  = 0;
  int be_err   = 0;
  logic [25:0] rd_log[$];
  logic [25:0] wa_log[$];
  logic [31:0] wd_log[$];

  int done_cnt = 0, busy_cnt = 0, overlap_err = 0, drop_err = 0;
  bit pend_r = 1'b0, pend_w = 1'b0;

  function automatic logic [31:0] srcword(input logic [25:0] a);
    return {6'h2A, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read side of the arbiter: ack after rd_delay cycles, then BL beats, complete on the last.
  initial begin
    int rcnt;
    logic [25:0] base;
    rcnt = 0;
    bus.blitr_ack = 1'b0; bus.blitr_valid = 1'b0; bus.blitr_complete = 1'b0; bus.blitr_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (bus.blitr_request && !reset) begin
        if (rcnt >= rd_delay) begin
          bus.blitr_ack = 1'b1;
          rd_log.push_back(bus.blitr_address);
          base = bus.blitr_address;
          rd_active = 1'b1;
          rcnt = 0;
          @(negedge clock);
          bus.blitr_ack = 1'b0;
          for (int i = 0; i < BL; i++) begin
            if (rd_gaps && (i == 3 || i == 9)) begin
              bus.blitr_valid = 1'b0;
              bus.blitr_complete = 1'b0;
              repeat (2) @(negedge clock);
            end
            rd_beat = i;
            bus.blitr_valid = 1'b1;
            bus.blitr_rdata = srcword(base + 26'(4 * i));
            bus.blitr_complete = (i == BL - 1);
            @(negedge clock);
          end
          bus.blitr_valid = 1'b0;
          bus.blitr_complete = 1'b0;
          rd_active = 1'b0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Write side: ack after wr_delay cycles of request, logging each accepted word.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.blitw_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.blitw_request && !reset) begin
        if (wcnt >= wr_delay) begin
          bus.blitw_ack = 1'b1;
          wa_log.push_back(bus.blitw_address);
          wd_log.push_back(bus.blitw_wdata);
          if (bus.blitw_byte_en !== 4'hF) be_err++;
          wcnt = 0;
        end else begin
          bus.blitw_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.blitw_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Protocol monitor: requests held until ack, no read/write overlap, pulse counts.
  always @(posedge clock) begin
    if (pend_r && !bus.blitr_request) drop_err <= drop_err + 1;
    if (pend_w && !bus.blitw_request) drop_err <= drop_err + 1;
    pend_r <= bus.blitr_request && !bus.blitr_ack && !reset;
    pend_w <= bus.blitw_request && !bus.blitw_ack && !reset;
    if (bus.blitr_request && bus.blitw_request) overlap_err <= overlap_err + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [25:0] s, input logic [25:0] d, input int w, input int h,
                             input logic [15:0] ss, input logic [15:0] ds);
    @(negedge clock);
    src_addr = s; dst_addr = d; width_words = 12'(w); height = 12'(h);
    src_stride = ss; dst_stride = ds; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    repeat (4) @(negedge clock);
  endtask

  task automatic check_copy(input string tag, input logic [25:0] s, input logic [25:0] d,
                            input int w, input int h, input logic [15:0] ss, input logic [15:0] ds,
                            input bit fill, input logic [31:0] fv, input int rb, input int wb);
    logic [25:0] er[$];
    logic [25:0] ea[$];
    logic [31:0] ed[$];
    logic [25:0] srow, drow;
    int col, step;
    srow = {s[25:2], 2'b00};
    drow = {d[25:2], 2'b00};
    for (int r = 0; r < h; r++) begin
      col = 0;
      while (col < w) begin
        er.push_back(srow + 26'(4 * col));
        step = (w - col > BL) ? BL : (w - col);
        col += step;
      end
      for (int c = 0; c < w; c++) begin
        ea.push_back(drow + 26'(4 * c));
        ed.push_back(fill ? fv : srcword(srow + 26'(4 * c)));
      end
      srow = srow + {10'd0, ss};
      drow = drow + {10'd0, ds};
    end
    if (fill) er.delete();
    check({tag, "_nreads"}, 64'(rd_log.size() - rb), 64'(er.size()));
    for (int i = 0; i < er.size() && rb + i < rd_log.size(); i++)
      check($sformatf("%s_rdaddr%0d", tag, i), 64'(rd_log[rb + i]), 64'(er[i]));
    check({tag, "_nwrites"}, 64'(wa_log.size() - wb), 64'(ea.size()));
    for (int i = 0; i < ea.size() && wb + i < wa_log.size(); i++) begin
      check($sformatf("%s_wraddr%0d", tag, i), 64'(wa_log[wb + i]), 64'(ea[i]));
      check($sformatf("%s_wrdata%0d", tag, i), 64'(wd_log[wb + i]), 64'(ed[i]));
    end
  endtask

  initial begin
    int rb, wb, db, bb, ob, drb;
    bit hit;
    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; width_words = '0; height = '0; src_stride = '0; dst_stride = '0;
`ifdef BLIT_FILL_EN
    fill_mode = 1'b0; fill_value = 32'd0;
`endif
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rreq", 64'(bus.blitr_request), 64'(0));
    check("rst_wreq", 64'(bus.blitw_request), 64'(0));
    check("rst_raddr", 64'(bus.blitr_address), 64'(0));
    check("rst_waddr", 64'(bus.blitw_address), 64'(0));
    check("rst_wdata", 64'(bus.blitw_wdata), 64'(0));
    check("rst_byte_en", 64'(bus.blitw_byte_en), 64'(4'hF));
    reset = 1'b0;

    // 4x2 copy, same-cycle acks
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt; ob = overlap_err; drb = drop_err;
    pulse_start(26'h1000, 26'h2000, 4, 2, 16'h100, 16'h200);
    check("t1_busy_rise", 64'(busy), 64'(1));
    wait_done("t1");
    check_copy("t1", 26'h1000, 26'h2000, 4, 2, 16'h100, 16'h200, 1'b0, 32'd0, rb, wb);
    check("t1_done_pulses", 64'(done_cnt - db), 64'(1));

    // Row wider than a burst: second burst keeps only 4 of 16 beats
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
    pulse_start(26'h3000, 26'h4000, 20, 1, 16'h0, 16'h0);
    wait_done("t2");
    check_copy("t2", 26'h3000, 26'h4000, 20, 1, 16'h0, 16'h0, 1'b0, 32'd0, rb, wb);
    check("t2_done_pulses", 64'(done_cnt - db), 64'(1));

    // Delayed acks and gaps in the read data
    rd_delay = 3; wr_delay = 3; rd_gaps = 1'b1;
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
    pulse_start(26'h5004, 26'h6008, 5, 2, 16'h20, 16'h40);
    wait_done("t3");
    check_copy("t3", 26'h5004, 26'h6008, 5, 2, 16'h20, 16'h40, 1'b0, 32'd0, rb, wb);
    check("t3_done_pulses", 64'(done_cnt - db), 64'(1));
    check("t3_req_held", 64'(drop_err - drb), 64'(0));

    // Zero height: immediate done, no busy, no traffic
    rd_delay = 0; wr_delay = 0; rd_gaps = 1'b0;
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt; bb = busy_cnt;
    pulse_start(26'h1000, 26'h2000, 4, 0, 16'h100, 16'h200);
    check("t4_done_next", 64'(done), 64'(1));
    check("t4_busy_low", 64'(busy), 64'(0));
    @(negedge clock);
    check("t4_done_single", 64'(done), 64'(0));
    repeat (4) @(negedge clock);
    check("t4_nreads", 64'(rd_log.size() - rb), 64'(0));
    check("t4_nwrites", 64'(wa_log.size() - wb), 64'(0));
    check("t4_busy_cycles", 64'(busy_cnt - bb), 64'(0));
    check("t4_done_pulses", 64'(done_cnt - db), 64'(1));

    // Zero width behaves the same
    db = done_cnt;
    pulse_start(26'h1000, 26'h2000, 0, 3, 16'h100, 16'h200);
    check("t4w_done_next", 64'(done), 64'(1));
    check("t4w_busy_low", 64'(busy), 64'(0));

    // A second start while busy is ignored
    rd_delay = 3; wr_delay = 3;
    repeat (2) @(negedge clock);
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt;
    pulse_start(26'h1200, 26'h2400, 3, 2, 16'h10, 16'h20);
    repeat (4) @(negedge clock);
    pulse_start(26'h0000, 26'h0500, 7, 3, 16'h40, 16'h40);
    wait_done("t4s");
    repeat (20) @(negedge clock);
    check_copy("t4s", 26'h1200, 26'h2400, 3, 2, 16'h10, 16'h20, 1'b0, 32'd0, rb, wb);
    check("t4s_done_pulses", 64'(done_cnt - db), 64'(1));

    // Address wrap-around at the top of the 64 MiB space
    rd_delay = 0; wr_delay = 0;
    rb = rd_log.size(); wb = wa_log.size();
    pulse_start(26'h3FF_FFF0, 26'h3FF_FFF8, 4, 2, 16'h10, 16'h10);
    wait_done("t6");
    check_copy("t6", 26'h3FF_FFF0, 26'h3FF_FFF8, 4, 2, 16'h10, 16'h10, 1'b0, 32'd0, rb, wb);

    // Reset while 5 read beats are still outstanding
    rb = rd_log.size(); wb = wa_log.size();
    pulse_start(26'h7000, 26'h8000, 8, 1, 16'h0, 16'h0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (rd_active && rd_beat == 10) begin
        hit = 1'b1;
        break;
      end
    end
    check("t5_reached_beat", 64'(hit), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_rreq_low", 64'(bus.blitr_request), 64'(0));
    check("t5_wreq_low", 64'(bus.blitw_request), 64'(0));
    check("t5_busy_low", 64'(busy), 64'(0));
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!rd_active) begin
        hit = 1'b1;
        break;
      end
    end
    check("t5_burst_drained", 64'(hit), 64'(1));
    repeat (3) @(negedge clock);
    check("t5_no_writes", 64'(wa_log.size() - wb), 64'(0));
    check("t5_still_idle", 64'(busy), 64'(0));
    rb = rd_log.size(); wb = wa_log.size();
    pulse_start(26'h7100, 26'h8100, 3, 1, 16'h0, 16'h0);
    wait_done("t5b");
    check_copy("t5b", 26'h7100, 26'h8100, 3, 1, 16'h0, 16'h0, 1'b0, 32'd0, rb, wb);

`ifdef BLIT_FILL_EN
    // Solid fill: no reads, every write carries the fill value
    rb = rd_log.size(); wb = wa_log.size();
    fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
    pulse_start(26'h0100, 26'h9000, 3, 3, 16'h40, 16'h30);
    fill_mode = 1'b0; fill_value = 32'd0;
    wait_done("t7");
    check_copy("t7", 26'h0100, 26'h9000, 3, 3, 16'h40, 16'h30, 1'b1, 32'hDEAD_BEEF, rb, wb);
`endif

    check("overlap_cycles", 64'(overlap_err - ob), 64'(0));
    check("byte_en_errors", 64'(be_err), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
